// File: rtl/prog_run_sched_pkg.sv
// Shared types and helpers for the program-run scheduler: FSM state encoding,
// return-value width and the round-robin pick function.
package prog_run_pkg;

   localparam int RET_W   = 32;
   localparam int MAX_REQ = 8;
   localparam int PTR_W   = 3;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      MASK  = 3'd2,
      RUN   = 3'd3,
      DONE  = 3'd4
   } state_t;

   // One-hot winner: first set bit searching from ptr+1 upward, wrapping at n.
   function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                  input logic [PTR_W-1:0]   ptr,
                                                  input int                 n);
      logic [MAX_REQ-1:0] win;
      int                 base;
      int                 idx;
      win  = '0;
      base = int'(ptr);
      for (int k = 1; k <= MAX_REQ; k++) begin
         idx = (base + k) % n;
         if (k <= n && win == '0 && req[idx[PTR_W-1:0]]) begin
            win[idx[PTR_W-1:0]] = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/prog_run_sched_if.sv
// Requester and program-core signals of the scheduler. The master modport is
// the scheduler itself; the slave modport is the environment (hosts + core).
interface prog_run_sched_if
   import prog_run_pkg::*;
#(
   parameter int NUM_REQ = 4
) ();

   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] grant;
   logic               busy;
   logic               done;
   logic [RET_W-1:0]   result;
   logic               err;
   logic               prog_start;
   logic               prog_finish;
   logic [RET_W-1:0]   prog_ret;

   modport master (
      input  req,
      input  prog_finish,
      input  prog_ret,
      output grant,
      output busy,
      output done,
      output result,
      output err,
      output prog_start
   );

   modport slave (
      output req,
      output prog_finish,
      output prog_ret,
      input  grant,
      input  busy,
      input  done,
      input  result,
      input  err,
      input  prog_start
   );

endinterface

// File: rtl/prog_run_sched_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot winner and a pointer to the last
// winner, which only moves when the scheduler is idle and a request is present.
module rr_arbiter
   import prog_run_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] win
);

   logic [PTR_W-1:0]   ptr;
   logic [PTR_W-1:0]   win_idx;
   logic [MAX_REQ-1:0] req_x;
   logic [MAX_REQ-1:0] win_x;

   always_comb begin
      // NOTE: every variable gets a default before any conditional write so no latch is inferred.
      req_x                = '0;
      req_x[NUM_REQ-1:0]   = req;
      win_x                = rr_pick(req_x, ptr, NUM_REQ);
      win                  = win_x[NUM_REQ-1:0];
   end

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win[i]) win_idx = PTR_W'(i);
      end
   end

   // Pointer resets to the last index so requester 0 wins first.
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
      if (!rst_n) begin
         ptr <= PTR_W'(NUM_REQ - 1);
      end else if (en && |req) begin
         ptr <= win_idx;
      end
   end

endmodule

// File: rtl/prog_run_sched.sv
// Round-robin scheduler sharing one program core between NUM_REQ requesters.
// Define PROG_RUN_CYCLES_EN to add the run_cycles output (RUN-state cycle count).
module prog_run_sched
   import prog_run_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int MASK_CYC = 4,
   parameter int TIMEOUT  = 1024,
   parameter int CW       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   prog_run_sched_if.master bus
`ifdef PROG_RUN_CYCLES_EN
   ,
   output logic [CW-1:0]    run_cycles
`endif
);

   localparam logic [CW-1:0] MASK_LAST = CW'(MASK_CYC - 1);
   localparam logic [CW-1:0] TO_LAST   = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
   localparam logic [CW-1:0] CNT_MAX   = '1;

   state_t             state;
   state_t             state_nxt;
   logic [NUM_REQ-1:0] grant_q;
   logic [NUM_REQ-1:0] win;
   logic [CW-1:0]      cnt;
   logic [CW-1:0]      cnt_inc;
   logic [RET_W-1:0]   result_q;
   logic               err_q;
   logic               arb_en;
   logic               mask_end;
   logic               timeout_hit;

   assign arb_en      = (state == IDLE);
   assign cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
   assign mask_end    = (cnt == MASK_LAST);
   assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (arb_en),
      .req   (bus.req),
      .win   (win)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (|bus.req) state_nxt = START;
         START:   state_nxt = MASK;
         MASK:    if (mask_end) state_nxt = RUN;
         RUN:     if (bus.prog_finish || timeout_hit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A single counter times both the finish mask and the RUN timeout.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         grant_q  <= '0;
         cnt      <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         unique case (state)
            IDLE:  if (|bus.req) grant_q <= win;
            START: cnt <= '0;
            MASK:  cnt <= mask_end ? '0 : cnt_inc;
            RUN: begin
               if (bus.prog_finish) begin
                  result_q <= bus.prog_ret;
                  err_q    <= 1'b0;
               end else if (timeout_hit) begin
                  result_q <= '0;
                  err_q    <= 1'b1;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            DONE:    grant_q <= '0;
            default: grant_q <= '0;
         endcase
      end
   end

`ifdef PROG_RUN_CYCLES_EN
   // Loaded on the RUN->DONE edge; cnt_inc already counts the finishing cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         run_cycles <= '0;
      end else if (state == RUN && state_nxt == DONE) begin
         run_cycles <= cnt_inc;
      end
   end
`endif

   always_comb begin
      bus.grant      = grant_q;
      bus.busy       = (state != IDLE);
      bus.done       = (state == DONE);
      bus.prog_start = (state == START);
      bus.result     = result_q;
      bus.err        = err_q;
   end

endmodule
